pwm_duty_decoder: RTL
=====================

# pwm_duty_decoder

Receive-side counterpart to the PWM brightness generator: samples a PWM waveform (for example the LED drive line fed back into the FPGA) and measures its period and high time in clock cycles. It quantizes the measured duty cycle to the generator's brightness steps (0/25/50/75/100 %). It also flags a stuck-high or stuck-low line. It sits beside the top PWM generator for on-chip self-check and feeds status/debug logic.

## Interface

- `PERIOD_W`, default 20: width of the cycle counters and of the `period_out` / `high_out` outputs.
- `TIMEOUT`, default 1000000: number of cycles without a rising edge before a stuck report is issued. Must satisfy 2 ≤ TIMEOUT < 2^PERIOD_W.

Ports:

- `tp_clk`, input, 1 bit: system clock, the only clock.
- `tp_rst`, input, 1 bit: reset, synchronous and active-high.
- `pwm_in`, input, 1 bit: PWM waveform, asynchronous to `tp_clk`.
- `valid`, output, 1 bit: one-cycle pulse when a new report is presented.
- `period_out`, output, PERIOD_W bits: measured period in cycles; 0 on a stuck report.
- `high_out`, output, PERIOD_W bits: measured high time in cycles; 0 on a stuck report.
- `level`, output, 3 bits: quantized brightness, 0..4 meaning 0/25/50/75/100 %.
- `stuck`, output, 1 bit: 1 when the current report is a timeout report.

## Operation

**Input synchronizer**
- Two flops, `s1` then `s2`, followed by a delay flop `s3`.
- `rise = s2 & ~s3`. Only `s2` is used internally.

**Counters**
- `cnt_p` and `cnt_h`, each PERIOD_W bits.
- On a cycle with `rise`: both counters load 1.
- On any other cycle: `cnt_p += 1`, and `cnt_h += s2`.
- Neither counter can exceed TIMEOUT, so no wrap occurs.

**FSM states**
- **IDLE**: no valid reference edge yet. Entered from reset and after any stuck report.
  - `rise` → load counters, go to MEAS, no report.
  - `cnt_p == TIMEOUT-1` with no `rise` → issue stuck report, `cnt_p ← 0`, `cnt_h ← 0`, stay in IDLE. Stuck reports therefore repeat every TIMEOUT cycles while the line stays flat.
- **MEAS**:
  - `rise` → issue measurement report from the pre-update counter values, load counters, stay in MEAS.
  - `cnt_p == TIMEOUT-1` with no `rise` → issue stuck report, go to IDLE.
- If `rise` and the timeout condition occur in the same cycle, `rise` wins.

**Measurement report** (registered)
- `period_out ← cnt_p`, `high_out ← cnt_h`, `stuck ← 0`.
- `level` = number of thresholds k ∈ {1,3,5,7} for which `8*cnt_h ≥ k*cnt_p`.
- Compare in PERIOD_W+3 bits so nothing overflows.
- Ties round up.

**Stuck report**
- `period_out ← 0`, `high_out ← 0`, `stuck ← 1`.
- `level ← 4` if `s2 == 1`, otherwise `level ← 0`.

**Output holding**
- `period_out`, `high_out`, `level` and `stuck` hold their values until the next report.
- `valid` is high for exactly one cycle per report.

**Reset** (`tp_rst = 1` at a `tp_clk` edge)
- All synchronizer flops, counters and outputs go to 0; state goes to IDLE.
- This applies in any state, including mid-period. The partial measurement is discarded and no report is issued.

## Timing

- Latency from a `pwm_in` rising transition to the `rise` cycle: 2–3 clocks, depending on synchronizer alignment.
- Report outputs and `valid` are registered: they update on the clock edge that ends the `rise` (or timeout) cycle.
- `valid` is visible the cycle after `rise`.
- The first rising edge after reset or after a stuck report produces no report. The first report appears at the second rising edge.
- Minimum measurable period: 2 cycles. Pulses narrower than about 1 clock may be missed; this is acceptable.
- Steady-state outputs for a PWM with period P cycles and high time H cycles: `period_out = P`, `high_out = H`, exact.

## Test plan

Benches use PERIOD_W = 8 and TIMEOUT = 64 with a 20 ns clock.

1. Reset, then PWM with P=40, H=10 → first `valid` at the second rising edge with `period_out=40`, `high_out=10`, `level=1`, `stuck=0`; identical reports every 40 cycles.
2. Change the duty to H=20, then H=30, at P=40 → `level=2`, then `level=3`; `high_out` tracks H exactly from the first full period after the change.
3. Tie boundary: P=40, H=15 → `level=2`. P=40, H=14 → `level=1`. P=40, H=35 → `level=4`.
4. Hold `pwm_in` high after an established PWM → after 64 cycles without `rise`, `valid` pulses with `stuck=1`, `level=4`, `period_out=0`; it repeats every 64 cycles. Hold low → the same with `level=0`.
5. Assert `tp_rst` for 1 cycle in mid-period → all outputs 0 the next cycle, no `valid`; after release, the next `valid` occurs only at the second rising edge.
6. Arrange for a rising edge to reach `rise` on the exact cycle `cnt_p == 63` → a measurement report with `period_out=63` and `stuck=0`; no stuck report is issued.

Source files
------------

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder
// Measures the period and high time of an externally supplied PWM waveform
// in tp_clk cycles and quantizes the duty cycle to five brightness steps
// (0/25/50/75/100 %). A line that shows no rising edge for TIMEOUT cycles
// produces a repeating "stuck" report whose level tells high from low.
//
// Parameters:
//   PERIOD_W   width of the cycle counters and of period_out/high_out
//   TIMEOUT    cycles without a rising edge before a stuck report
//              (2 <= TIMEOUT < 2**PERIOD_W)
// Ports:
//   tp_clk     system clock
//   tp_rst     synchronous active-high reset
//   pwm_in     PWM waveform, asynchronous to tp_clk
//   valid      one-cycle pulse when a new report is presented
//   period_out measured period in cycles (0 on a stuck report)
//   high_out   measured high time in cycles (0 on a stuck report)
//   level      quantized brightness 0..4
//   stuck      1 when the current report is a timeout report
module pwm_duty_decoder #(
  parameter int PERIOD_W = 20,
  parameter int TIMEOUT  = 1000000
) (
  input  logic                tp_clk,
  input  logic                tp_rst,
  input  logic                pwm_in,
  output logic                valid,
  output logic [PERIOD_W-1:0] period_out,
  output logic [PERIOD_W-1:0] high_out,
  output logic [2:0]          level,
  output logic                stuck
);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  localparam logic [PERIOD_W-1:0] CNT_ZERO = '0;
  localparam logic [PERIOD_W-1:0] CNT_ONE  = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] TO_LAST  = PERIOD_W'(TIMEOUT - 1);

  // Number of thresholds k in {1,3,5,7} with 8*h >= k*p. Everything is
  // widened by 3 bits so 8*h and 7*p cannot overflow; >= makes ties round up.
  function automatic logic [2:0] duty_level(
    input logic [PERIOD_W-1:0] p,
    input logic [PERIOD_W-1:0] h
  );
    logic [PERIOD_W+2:0] h8;
    logic [PERIOD_W+2:0] p1;
    logic [PERIOD_W+2:0] p3;
    logic [PERIOD_W+2:0] p5;
    logic [PERIOD_W+2:0] p7;
    logic [2:0]          lvl;
    h8  = {h, 3'b000};
    p1  = {3'b000, p};
    p3  = (p1 << 1) + p1;
    p5  = (p1 << 2) + p1;
    p7  = (p1 << 3) - p1;
    lvl = 3'd0;
    if (h8 >= p1) lvl = lvl + 3'd1;
    if (h8 >= p3) lvl = lvl + 3'd1;
    if (h8 >= p5) lvl = lvl + 3'd1;
    if (h8 >= p7) lvl = lvl + 3'd1;
    return lvl;
  endfunction

  logic                s1_r;
  logic                s2_r;
  logic                s3_r;
  logic [PERIOD_W-1:0] cnt_p_r;
  logic [PERIOD_W-1:0] cnt_h_r;
  state_t              state_r;
  logic                rise_s;
  logic                timeout_s;

  // Edge detect on the synchronized line and the no-edge timeout condition.
  always_comb begin
    rise_s    = s2_r & ~s3_r;
    timeout_s = (cnt_p_r == TO_LAST);
  end

  // Synchronizer, counters, state machine and registered report outputs.
  always_ff @(posedge tp_clk) begin
    if (tp_rst) begin
      s1_r       <= 1'b0;
      s2_r       <= 1'b0;
      s3_r       <= 1'b0;
      cnt_p_r    <= CNT_ZERO;
      cnt_h_r    <= CNT_ZERO;
      state_r    <= IDLE;
      valid      <= 1'b0;
      period_out <= CNT_ZERO;
      high_out   <= CNT_ZERO;
      level      <= 3'd0;
      stuck      <= 1'b0;
    end else begin
      s1_r  <= pwm_in;
      s2_r  <= s1_r;
      s3_r  <= s2_r;
      valid <= 1'b0;
      if (rise_s) begin
        // A rising edge always wins over a coincident timeout.
        cnt_p_r <= CNT_ONE;
        cnt_h_r <= CNT_ONE;
        state_r <= MEAS;
        case (state_r)
          MEAS: begin
            // Report uses the counter values from before the reload.
            valid      <= 1'b1;
            period_out <= cnt_p_r;
            high_out   <= cnt_h_r;
            level      <= duty_level(cnt_p_r, cnt_h_r);
            stuck      <= 1'b0;
          end
          default: begin
            // First edge only establishes the reference; nothing to report.
            valid <= 1'b0;
          end
        endcase
      end else if (timeout_s) begin
        // Restarting from zero makes stuck reports repeat every TIMEOUT cycles.
        cnt_p_r    <= CNT_ZERO;
        cnt_h_r    <= CNT_ZERO;
        state_r    <= IDLE;
        valid      <= 1'b1;
        period_out <= CNT_ZERO;
        high_out   <= CNT_ZERO;
        level      <= s2_r ? 3'd4 : 3'd0;
        stuck      <= 1'b1;
      end else begin
        cnt_p_r <= cnt_p_r + CNT_ONE;
        cnt_h_r <= cnt_h_r + {{(PERIOD_W-1){1'b0}}, s2_r};
      end
    end
  end

endmodule
